rally_referee: RTL and testbench

Point/score controller downstream of the ball-shifting stage in the FPGA tennis game. It watches the 16-bit ball LED vector and both player buttons, and detects misses and early (faulty) swings. It awards points, keeps score, and decides who serves next. It drives enable/reload controls back to the ball stage and score/winner outputs to the display logic.

---
 rtl/rally_referee.sv | 190 +++++++++++++++++++
 tb/tb_rally_referee.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rally_referee.sv
// Point/score referee for the LED tennis game: detects misses and early swings, keeps score, picks the server.
// Optional deuce rule (win by two) is enabled by defining DEUCE_WIN_BY_TWO_EN.
module rally_referee #(
  parameter int unsigned WIN_SCORE  = 7,
  parameter int unsigned POINT_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] led,
  input  logic        serve_button_player1,
  input  logic        serve_button_player2,
  output logic        ball_enable,
  output logic        ball_load,
  output logic        load_side,
  output logic        server,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        point_p1,
  output logic        point_p2,
  output logic        game_over,
  output logic        winner
);

  typedef enum logic [1:0] {SERVE_WAIT, RALLY, POINT, GAME_OVER} state_t;

  localparam logic [3:0] WIN       = 4'(WIN_SCORE);
  localparam logic [3:0] CAP       = 4'(WIN_SCORE + 1);
  localparam logic [7:0] HOLD_LAST = 8'(POINT_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [7:0] hold_q, hold_d;
  logic       server_q, server_d, load_side_q, load_side_d;
  logic       ball_load_q, ball_load_d, pt1_q, pt1_d, pt2_q, pt2_d;
  logic       winner_q, winner_d, last_end_q, last_end_d;
  logic [1:0] btn_prev_q;

  logic       rise1, rise2, bad1, bad2;
  logic       award1, award2, replay;
  logic [3:0] inc1, inc2;
  logic       tie1, tie2, win1, win2;

  assign rise1 = serve_button_player1 & ~btn_prev_q[1];
  assign rise2 = serve_button_player2 & ~btn_prev_q[0];
  // A swing is only legal while the ball sits on the swinger's end LED.
  assign bad1  = rise1 & ~led[15];
  assign bad2  = rise2 & ~led[0];

  assign inc1 = (score1_q < CAP) ? score1_q + 4'd1 : score1_q;
  assign inc2 = (score2_q < CAP) ? score2_q + 4'd1 : score2_q;

`ifdef DEUCE_WIN_BY_TWO_EN
  assign tie1 = (inc1 == score2_q) && (inc1 >= WIN);
  assign tie2 = (inc2 == score1_q) && (inc2 >= WIN);
  assign win1 = (score1_q >= WIN) && ({1'b0, score1_q} >= {1'b0, score2_q} + 5'd2);
  assign win2 = (score2_q >= WIN) && ({1'b0, score2_q} >= {1'b0, score1_q} + 5'd2);
`else
  assign tie1 = 1'b0;
  assign tie2 = 1'b0;
  assign win1 = (score1_q >= WIN);
  assign win2 = (score2_q >= WIN);
`endif

  always_comb begin
    award1 = 1'b0;
    award2 = 1'b0;
    replay = 1'b0;
    if (led == 16'h0000) begin
      award1 = last_end_q;
      award2 = ~last_end_q;
    end else if (bad1 && bad2) begin
      replay = 1'b1;
    end else if (bad1) begin
      award2 = 1'b1;
    end else if (bad2) begin
      award1 = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    hold_d      = hold_q;
    server_d    = server_q;
    load_side_d = load_side_q;
    ball_load_d = 1'b0;
    pt1_d       = 1'b0;
    pt2_d       = 1'b0;
    winner_d    = winner_q;
    last_end_d  = last_end_q;
    case (state_q)
      SERVE_WAIT: begin
        if (server_q ? rise2 : rise1) state_d = RALLY;
      end
      RALLY: begin
        if (led[15]) last_end_d = 1'b0;
        if (led[0])  last_end_d = 1'b1;
        if (award1 || award2 || replay) begin
          state_d = POINT;
          hold_d  = '0;
        end
        if (award1) begin
          score1_d = tie1 ? WIN - 4'd1 : inc1;
          if (tie1) score2_d = WIN - 4'd1;
          pt1_d    = 1'b1;
          server_d = 1'b1;
        end
        if (award2) begin
          score2_d = tie2 ? WIN - 4'd1 : inc2;
          if (tie2) score1_d = WIN - 4'd1;
          pt2_d    = 1'b1;
          server_d = 1'b0;
        end
      end
      POINT: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (win1 || win2) begin
              state_d  = GAME_OVER;
              winner_d = ~win1;
            end else begin
              state_d     = SERVE_WAIT;
              ball_load_d = 1'b1;
              load_side_d = server_q;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      GAME_OVER: begin
        if (rise1 || rise2) begin
          score1_d    = '0;
          score2_d    = '0;
          server_d    = 1'b1;
          ball_load_d = 1'b1;
          load_side_d = 1'b1;
          state_d     = SERVE_WAIT;
        end
      end
      default: state_d = SERVE_WAIT;
    endcase
  end

  // Previous button levels reset high so a button held through reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SERVE_WAIT;
      score1_q    <= '0;
      score2_q    <= '0;
      hold_q      <= '0;
      server_q    <= 1'b1;
      load_side_q <= 1'b1;
      ball_load_q <= 1'b0;
      pt1_q       <= 1'b0;
      pt2_q       <= 1'b0;
      winner_q    <= 1'b0;
      last_end_q  <= 1'b1;
      btn_prev_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      hold_q      <= hold_d;
      server_q    <= server_d;
      load_side_q <= load_side_d;
      ball_load_q <= ball_load_d;
      pt1_q       <= pt1_d;
      pt2_q       <= pt2_d;
      winner_q    <= winner_d;
      last_end_q  <= last_end_d;
      btn_prev_q  <= {serve_button_player1, serve_button_player2};
    end
  end

  assign ball_enable = (state_q == RALLY);
  assign game_over   = (state_q == GAME_OVER);
  assign ball_load   = ball_load_q;
  assign load_side   = load_side_q;
  assign server      = server_q;
  assign score_p1    = score1_q;
  assign score_p2    = score2_q;
  assign point_p1    = pt1_q;
  assign point_p2    = pt2_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee: cycle-level rule model plus hand-computed literal checks.
module tb_rally_referee;
  localparam int W    = 7;
  localparam int HOLD = 8;

  logic        clk = 1'b0, reset = 1'b0, tick = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic [15:0] led = 16'h0000;
  logic        ball_enable, ball_load, load_side, server, point_p1, point_p2, game_over, winner;
  logic [3:0]  score_p1, score_p2;

  always #5 clk = ~clk;

  rally_referee #(.WIN_SCORE(W), .POINT_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .led(led),
    .serve_button_player1(b1), .serve_button_player2(b2),
    .ball_enable(ball_enable), .ball_load(ball_load), .load_side(load_side), .server(server),
    .score_p1(score_p1), .score_p2(score_p2), .point_p1(point_p1), .point_p2(point_p2),
    .game_over(game_over), .winner(winner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Rule model: phase of play, scores per player, whose serve, and who touched an end last.
  localparam int MW = 0, MR = 1, MP = 2, MO = 3;
  int m_mode, m_s1, m_s2, m_ticks;
  bit m_server, m_side, m_load, m_pt1, m_pt2, m_win, m_last, m_pb1, m_pb2;

  task automatic model_reset();
    m_mode = MW; m_s1 = 0; m_s2 = 0; m_ticks = 0;
    m_server = 1; m_side = 1; m_load = 0; m_pt1 = 0; m_pt2 = 0;
    m_win = 0; m_last = 1; m_pb1 = 1; m_pb2 = 1;
  endtask

  function automatic bit wins(int a, int b);
`ifdef DEUCE_WIN_BY_TWO_EN
    return (a >= W) && (a - b >= 2);
`else
    return (a >= W);
`endif
  endfunction

  task automatic model_award(int p);
    if (p == 1) begin
      m_s1 = (m_s1 + 1 > W + 1) ? W + 1 : m_s1 + 1;
      m_pt1 = 1; m_server = 1;
    end else begin
      m_s2 = (m_s2 + 1 > W + 1) ? W + 1 : m_s2 + 1;
      m_pt2 = 1; m_server = 0;
    end
`ifdef DEUCE_WIN_BY_TWO_EN
    if (m_s1 == m_s2 && m_s1 >= W) begin m_s1 = W - 1; m_s2 = W - 1; end
`endif
    m_mode = MP; m_ticks = 0;
  endtask

  task automatic model_step();
    bit r1, r2, f1, f2;
    r1 = b1 && !m_pb1; r2 = b2 && !m_pb2;
    m_pb1 = b1; m_pb2 = b2;
    m_load = 0; m_pt1 = 0; m_pt2 = 0;
    case (m_mode)
      MW: if (m_server ? r2 : r1) m_mode = MR;
      MR: begin
        f1 = r1 && !led[15];
        f2 = r2 && !led[0];
        if (led == 16'h0000) model_award(m_last == 0 ? 2 : 1);
        else if (f1 && f2) begin m_mode = MP; m_ticks = 0; end
        else if (f1) model_award(2);
        else if (f2) model_award(1);
        if (led[15]) m_last = 0;
        if (led[0])  m_last = 1;
      end
      MP: if (tick) begin
        m_ticks++;
        if (m_ticks == HOLD) begin
          if (wins(m_s1, m_s2))      begin m_mode = MO; m_win = 0; end
          else if (wins(m_s2, m_s1)) begin m_mode = MO; m_win = 1; end
          else begin m_mode = MW; m_load = 1; m_side = m_server; end
        end
      end
      default: if (r1 || r2) begin
        m_s1 = 0; m_s2 = 0; m_server = 1; m_load = 1; m_side = 1; m_mode = MW;
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs (winner only meaningful during game over).
  initial begin
    logic [15:0] act, exp;
    forever begin
      @(negedge clk);
      act = {ball_enable, ball_load, load_side, server, score_p1, score_p2,
             point_p1, point_p2, game_over, winner & game_over};
      exp = {m_mode == MR, m_load, m_side, m_server, 4'(m_s1), 4'(m_s2),
             m_pt1, m_pt2, m_mode == MO, m_win & (m_mode == MO)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic step(logic [15:0] l, bit t, bit p1, bit p2);
    led = l; tick = t; b1 = p1; b2 = p2;
    @(posedge clk);
    #1;
  endtask

  task automatic press(int p, logic [15:0] l);
    step(l, 0, p == 1, p == 2);
    step(l, 0, 0, 0);
  endtask

  task automatic hold();
    repeat (HOLD) begin
      step(16'h0000, 0, 0, 0);
      step(16'h0000, 1, 0, 0);
    end
  endtask

  // Current server serves, then the loser swings early with the ball mid-court.
  task automatic point_to(int p);
    press(m_server ? 2 : 1, 16'h0100);
    press(p == 1 ? 2 : 1, 16'h0100);
    hold();
  endtask

  initial begin
    // P2 held through reset release must not serve.
    reset = 0;
    step(16'h0000, 0, 0, 1); step(16'h0000, 0, 0, 1);
    reset = 1;
    step(16'h0000, 0, 0, 1); step(16'h0000, 0, 0, 1); step(16'h0000, 0, 0, 0);
    check("rst_enable", 16'(ball_enable), 16'd0);
    check("rst_server", 16'(server), 16'd1);
    check("rst_side", 16'(load_side), 16'd1);

    // Serve by P2, ball walks to P1's end and off: P1 missed.
    press(2, 16'h0001);
    check("serve_enable", 16'(ball_enable), 16'd1);
    for (int i = 0; i < 16; i++) step(16'h0001 << i, 1, 0, 0);
    step(16'h0000, 1, 0, 0);
    check("miss_pt2", 16'(point_p2), 16'd1);
    check("miss_score2", 16'(score_p2), 16'd1);
    check("miss_server", 16'(server), 16'd0);
    check("miss_enable", 16'(ball_enable), 16'd0);
    hold();
    check("miss_load", 16'(ball_load), 16'd1);
    check("miss_side", 16'(load_side), 16'd0);

    // P1 swings early mid-court: point to P2.
    press(1, 16'h8000);
    step(16'h0100, 0, 0, 0);
    step(16'h0100, 0, 1, 0);
    check("early_pt2", 16'(point_p2), 16'd1);
    check("early_score2", 16'(score_p2), 16'd2);
    step(16'h0100, 0, 0, 0);
    hold();
    check("early_load", 16'(ball_load), 16'd1);

    // Valid swing at P1's end: no referee action.
    press(1, 16'h8000);
    step(16'h8000, 0, 1, 0);
    check("valid_pts", 16'({point_p1, point_p2}), 16'd0);
    check("valid_enable", 16'(ball_enable), 16'd1);
    step(16'h8000, 0, 0, 0);
    check("valid_scores", 16'({score_p1, score_p2}), 16'h02);

    // Both swing early: replay.
    step(16'h0010, 0, 0, 0);
    step(16'h0010, 0, 1, 1);
    check("replay_pts", 16'({point_p1, point_p2}), 16'd0);
    check("replay_enable", 16'(ball_enable), 16'd0);
    check("replay_server", 16'(server), 16'd0);
    check("replay_scores", 16'({score_p1, score_p2}), 16'h02);
    step(16'h0010, 0, 0, 0);
    hold();
    check("replay_load", 16'(ball_load), 16'd1);
    check("replay_side", 16'(load_side), 16'd0);

    // Both swing with ball at P1's end: only P2 is early, P1 scores.
    press(1, 16'h8000);
    step(16'h8000, 0, 1, 1);
    check("both_pt1", 16'(point_p1), 16'd1);
    check("both_server", 16'(server), 16'd1);
    step(16'h8000, 0, 0, 0);
    hold();
    check("both_side", 16'(load_side), 16'd1);

    // Reach 3-2, serve, then reset mid-rally.
    point_to(1);
    point_to(1);
    press(2, 16'h0100);
    check("pre_rst_scores", 16'({score_p1, score_p2}), 16'h32);
    check("pre_rst_enable", 16'(ball_enable), 16'd1);
    reset = 0;
    #1;
    check("async_scores", 16'({score_p1, score_p2}), 16'h00);
    check("async_enable", 16'(ball_enable), 16'd0);
    check("async_server", 16'(server), 16'd1);
    step(16'h0100, 0, 0, 0); step(16'h0100, 0, 0, 0);
    reset = 1;
    step(16'h0100, 0, 0, 0); step(16'h0100, 0, 0, 0);
    check("post_rst_scores", 16'({score_p1, score_p2}), 16'h00);
    check("post_rst_state", 16'({ball_enable, game_over, ball_load}), 16'd0);

    // P2 takes 7 straight points.
    repeat (W) point_to(2);
    check("go_score2", 16'(score_p2), 16'd7);
    check("go_flag", 16'(game_over), 16'd1);
    check("go_winner", 16'(winner), 16'd1);
    check("go_enable", 16'(ball_enable), 16'd0);
    step(16'h0000, 0, 1, 0);
    check("new_load", 16'(ball_load), 16'd1);
    check("new_side", 16'(load_side), 16'd1);
    check("new_server", 16'(server), 16'd1);
    check("new_scores", 16'({score_p1, score_p2}), 16'h00);
    step(16'h0000, 0, 0, 0);

`ifdef DEUCE_WIN_BY_TWO_EN
    repeat (W - 1) begin point_to(1); point_to(2); end
    check("d_66", 16'({score_p1, score_p2}), 16'h66);
    point_to(1);
    check("d_76_scores", 16'({score_p1, score_p2}), 16'h76);
    check("d_76_over", 16'(game_over), 16'd0);
    point_to(2);
    check("d_77_back", 16'({score_p1, score_p2}), 16'h66);
    point_to(1);
    point_to(1);
    check("d_86_scores", 16'({score_p1, score_p2}), 16'h86);
    check("d_86_over", 16'(game_over), 16'd1);
    check("d_86_winner", 16'(winner), 16'd0);
`endif

    step(16'h0000, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
